// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the two-lane 16x16 partial-product operand sequencer.
// The state encoding matches the order in which the accumulator consumes the products.
package mult_seq_pkg;
    localparam int PP_CNT = 4;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        PP1,
        PP2,
        PP3,
        PP4,
        DRAIN
    } seq_state_t;
endpackage

// File: rtl/mult8x8_u.sv
// Combinational unsigned 8x8 -> 16 multiplier, one instance per lane.
// The result is at most 0xFE01, so 16 bits cannot overflow.
module mult8x8_u
    import mult_seq_pkg::*;
(
    input  logic [BYTE_W-1:0]   a,
    input  logic [BYTE_W-1:0]   b,
    output logic [2*BYTE_W-1:0] p
);
    assign p = {{BYTE_W{1'b0}}, a} * {{BYTE_W{1'b0}}, b};
endmodule

// File: rtl/mult16_pp_sequencer.sv
// Operand sequencer feeding the two-lane 16x16 partial-product accumulator: start pulse, four PPs, result handshake.
// Optional MULT_SEQ_PERF_EN adds op_count / stall_count performance counters.
module mult16_pp_sequencer
    import mult_seq_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      a0,
    input  logic [15:0]      b0,
    input  logic [15:0]      a1,
    input  logic [15:0]      b1,
    input  logic [TAG_W-1:0] in_tag,
    output logic             start,
    output logic [15:0]      mult_out1,
    output logic [15:0]      mult_out2,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [TAG_W-1:0] res_tag
`ifdef MULT_SEQ_PERF_EN
    ,
    output logic [31:0]      op_count,
    output logic [31:0]      stall_count
`endif
);
    seq_state_t state, state_nxt;

    logic [15:0]      a0_q, b0_q, a1_q, b1_q;
    logic [TAG_W-1:0] tag_q;
    logic             accept;
    logic             hi_a, hi_b, pp_phase;
    logic [BYTE_W-1:0]   a0_sel, b0_sel, a1_sel, b1_sel;
    logic [2*BYTE_W-1:0] p0, p1;

    assign accept = (state == IDLE) && in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a0_q  <= '0;
            b0_q  <= '0;
            a1_q  <= '0;
            b1_q  <= '0;
            tag_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a0_q  <= a0;
                b0_q  <= b0;
                a1_q  <= a1;
                b1_q  <= b1;
                tag_q <= in_tag;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        start     = 1'b0;
        res_valid = 1'b0;
        res_tag   = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = START;
            end
            START: begin
                start     = 1'b1;
                state_nxt = PP1;
            end
            PP1:   state_nxt = PP2;
            PP2:   state_nxt = PP3;
            PP3:   state_nxt = PP4;
            PP4:   state_nxt = DRAIN;
            DRAIN: begin
                res_valid = 1'b1;
                res_tag   = tag_q;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Product order: lo*lo, lo(a)*hi(b), hi(a)*lo(b), hi*hi.
    assign hi_a     = (state == PP3) || (state == PP4);
    assign hi_b     = (state == PP2) || (state == PP4);
    assign pp_phase = (state == PP1) || (state == PP2) || (state == PP3) || (state == PP4);

    assign a0_sel = hi_a ? a0_q[15:8] : a0_q[7:0];
    assign b0_sel = hi_b ? b0_q[15:8] : b0_q[7:0];
    assign a1_sel = hi_a ? a1_q[15:8] : a1_q[7:0];
    assign b1_sel = hi_b ? b1_q[15:8] : b1_q[7:0];

    mult8x8_u u_mul_lane0 (.a(a0_sel), .b(b0_sel), .p(p0));
    mult8x8_u u_mul_lane1 (.a(a1_sel), .b(b1_sel), .p(p1));

    assign mult_out1 = pp_phase ? p0 : 16'd0;
    assign mult_out2 = pp_phase ? p1 : 16'd0;

`ifdef MULT_SEQ_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count    <= '0;
            stall_count <= '0;
        end else begin
            if (res_valid && res_ready) op_count <= op_count + 32'd1;
            if (in_valid && !in_ready)  stall_count <= stall_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mult16_pp_sequencer.sv
// Directed bench for mult16_pp_sequencer with hand-computed partial products and accumulated results.
module tb_mult16_pp_sequencer;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      a0, b0, a1, b1;
    logic [TAG_W-1:0] in_tag;
    logic             start;
    logic [15:0]      mult_out1, mult_out2;
    logic             res_valid;
    logic             res_ready;
    logic [TAG_W-1:0] res_tag;
`ifdef MULT_SEQ_PERF_EN
    logic [31:0]      op_count, stall_count;
`endif

    int checks = 0;
    int errors = 0;

    mult16_pp_sequencer #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .in_tag(in_tag),
        .start(start), .mult_out1(mult_out1), .mult_out2(mult_out2),
        .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag)
`ifdef MULT_SEQ_PERF_EN
        , .op_count(op_count), .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full operation with res_ready high; e1/e2 pack PP4..PP1 from MSB to LSB.
    task automatic run_op(input logic [15:0] x0, input logic [15:0] y0,
                          input logic [15:0] x1, input logic [15:0] y1,
                          input logic [3:0] tg,
                          input logic [63:0] e1, input logic [63:0] e2,
                          input logic [31:0] prod1, input logic [31:0] prod2);
        logic [31:0] acc1, acc2;
        int sh;
        acc1 = '0;
        acc2 = '0;
        a0 = x0; b0 = y0; a1 = x1; b1 = y1; in_tag = tg;
        in_valid = 1'b1;
        res_ready = 1'b1;
        chk("t0_in_ready", in_ready, 1);
        chk("t0_start", start, 0);
        tick();
        in_valid = 1'b0;
        chk("t1_start", start, 1);
        chk("t1_in_ready", in_ready, 0);
        chk("t1_mult_out1", mult_out1, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("pp%0d_mult_out1", k + 1), mult_out1, e1[k*16 +: 16]);
            chk($sformatf("pp%0d_mult_out2", k + 1), mult_out2, e2[k*16 +: 16]);
            chk($sformatf("pp%0d_start", k + 1), start, 0);
            chk($sformatf("pp%0d_res_valid", k + 1), res_valid, 0);
            sh = (k == 0) ? 0 : (k == 3) ? 16 : 8;
            acc1 = acc1 + ({16'd0, mult_out1} << sh);
            acc2 = acc2 + ({16'd0, mult_out2} << sh);
            tick();
        end
        chk("t6_res_valid", res_valid, 1);
        chk("t6_res_tag", res_tag, tg);
        chk("t6_mult_out1", mult_out1, 0);
        chk("t6_in_ready", in_ready, 0);
        chk("lane0_product", acc1, prod1);
        chk("lane1_product", acc2, prod2);
        tick();
        chk("t7_res_valid", res_valid, 0);
        chk("t7_in_ready", in_ready, 1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        res_ready = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; in_tag = '0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_start", start, 0);
        chk("rst_mult_out1", mult_out1, 0);
        chk("rst_mult_out2", mult_out2, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_tag", res_tag, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Single operation
        run_op(16'h1234, 16'h5678, 16'hFFFF, 16'hFFFF, 4'hA,
               {16'h060C, 16'h0870, 16'h1178, 16'h1860},
               {16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01},
               32'h06260060, 32'hFFFE0001);

        // Zero / identity operands
        run_op(16'h0000, 16'hBEEF, 16'h0001, 16'hBEEF, 4'h5,
               {16'h0000, 16'h0000, 16'h0000, 16'h0000},
               {16'h0000, 16'h0000, 16'h00BE, 16'h00EF},
               32'h00000000, 32'h0000BEEF);

        // Back-to-back with in_valid held: accepts at T0 and T7, starts at T1 and T8
        a0 = 16'h0102; b0 = 16'h0304; a1 = 16'h0506; b1 = 16'h0708; in_tag = 4'h3;
        in_valid = 1'b1;
        res_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            chk($sformatf("b2b_c%0d_start", c), start, (c == 1 || c == 8) ? 1 : 0);
            chk($sformatf("b2b_c%0d_in_ready", c), in_ready, (c == 0 || c == 7 || c == 14) ? 1 : 0);
            chk($sformatf("b2b_c%0d_res_valid", c), res_valid, (c == 6 || c == 13) ? 1 : 0);
            if (c == 7) begin
                tick();
                in_valid = 1'b0;
            end else begin
                tick();
            end
        end

        // Backpressure: 5 cycles of res_ready low in DRAIN with a new op waiting
        a0 = 16'h00FF; b0 = 16'h0002; a1 = 16'h0100; b1 = 16'h0100; in_tag = 4'hC;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        res_ready = 1'b0;
        repeat (5) tick();
        chk("bp_enter_res_valid", res_valid, 1);
        a0 = 16'h0011; b0 = 16'h0011; a1 = 16'h0000; b1 = 16'h0000; in_tag = 4'h7;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d_res_valid", c), res_valid, 1);
            chk($sformatf("bp%0d_res_tag", c), res_tag, 4'hC);
            chk($sformatf("bp%0d_in_ready", c), in_ready, 0);
            chk($sformatf("bp%0d_mult_out1", c), mult_out1, 0);
            tick();
        end
        res_ready = 1'b1;
        chk("bp_release_res_valid", res_valid, 1);
        tick();
        chk("bp_after_in_ready", in_ready, 1);
        chk("bp_after_res_valid", res_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("bp_next_start", start, 1);
        tick();
        chk("bp_next_pp1", mult_out1, 16'h0121);
        repeat (5) tick();
        chk("bp_next_idle", in_ready, 1);

        // Reset asserted during PP3
        a0 = 16'h1234; b0 = 16'h5678; a1 = 16'hFFFF; b1 = 16'hFFFF; in_tag = 4'h9;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_rst_pp3", mult_out1, 16'h0870);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_mult_out1", mult_out1, 0);
        chk("midrst_mult_out2", mult_out2, 0);
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_start", start, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("postrst%0d_res_valid", c), res_valid, 0);
        end
        run_op(16'h0003, 16'h0005, 16'h0200, 16'h0300, 4'h1,
               {16'h0000, 16'h0000, 16'h0000, 16'h000F},
               {16'h0006, 16'h0000, 16'h0000, 16'h0000},
               32'h0000000F, 32'h00060000);

`ifdef MULT_SEQ_PERF_EN
        rst = 1'b1;
        #1;
        chk("perf_rst_op_count", op_count, 0);
        chk("perf_rst_stall_count", stall_count, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        res_ready = 1'b1;
        in_valid = 1'b1;
        repeat (15) tick();
        in_valid = 1'b0;
        repeat (6) tick();
        chk("perf_op_count", op_count, 3);
        chk("perf_stall_count", stall_count, 12);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
